// File: rtl/dvi_timing_ctrl.sv
// Video timing generator and RGB555 -> IDF=3 half-word packer for the CH7301C.
// Optional saturating missed-pixel counter enabled by DVI_UNDERFLOW_COUNT_EN.
module dvi_timing_ctrl #(
  parameter int unsigned HORI_SYNC_PULSE   = 136,
  parameter int unsigned HORI_BACK_PORCH   = 160,
  parameter int unsigned HORI_VISIBLE_AREA = 1024,
  parameter int unsigned HORI_FRONT_PORCH  = 24,
  parameter int unsigned VERT_SYNC_PULSE   = 6,
  parameter int unsigned VERT_BACK_PORCH   = 29,
  parameter int unsigned VERT_VISIBLE_AREA = 768,
  parameter int unsigned VERT_FRONT_PORCH  = 3,
  parameter bit          SYNC_POLARITY     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        frame_start,
  output logic        dvi_h,
  output logic        dvi_v,
  output logic        dvi_de,
  output logic [11:0] dvi_data_rise,
  output logic [11:0] dvi_data_fall,
  output logic        underflow,
  output logic [15:0] underflow_count
);

  localparam int unsigned HW  = HORI_SYNC_PULSE + HORI_BACK_PORCH +
                                HORI_VISIBLE_AREA + HORI_FRONT_PORCH;
  localparam int unsigned VW  = VERT_SYNC_PULSE + VERT_BACK_PORCH +
                                VERT_VISIBLE_AREA + VERT_FRONT_PORCH;
  localparam int unsigned HCW = $clog2(HW);
  localparam int unsigned VCW = $clog2(VW);
  localparam int unsigned H_VIS_START = HORI_SYNC_PULSE + HORI_BACK_PORCH;
  localparam int unsigned H_VIS_END   = H_VIS_START + HORI_VISIBLE_AREA;
  localparam int unsigned V_VIS_START = VERT_SYNC_PULSE + VERT_BACK_PORCH;
  localparam int unsigned V_VIS_END   = V_VIS_START + VERT_VISIBLE_AREA;

  logic [HCW-1:0] h_cnt_q, h_cnt_d;
  logic [VCW-1:0] v_cnt_q, v_cnt_d;
  logic           frame_start_q, frame_start_d;
  logic           dvi_h_q, dvi_h_d;
  logic           dvi_v_q, dvi_v_d;
  logic           dvi_de_q, dvi_de_d;
  logic [11:0]    rise_q, rise_d;
  logic [11:0]    fall_q, fall_d;
  logic           underflow_q, underflow_d;

  logic h_sync_c, h_vis_c, v_sync_c, v_vis_c;
  logic hsync_c, de_c, take_c, miss_c;

  // Region decode straight from the counters; these are the pre-register terms.
  always_comb begin
    h_sync_c = (h_cnt_q < HCW'(HORI_SYNC_PULSE));
    h_vis_c  = (h_cnt_q >= HCW'(H_VIS_START)) && (h_cnt_q < HCW'(H_VIS_END));
    v_sync_c = (v_cnt_q < VCW'(VERT_SYNC_PULSE));
    v_vis_c  = (v_cnt_q >= VCW'(V_VIS_START)) && (v_cnt_q < VCW'(V_VIS_END));
    hsync_c  = h_sync_c && v_vis_c;
    de_c     = h_vis_c && v_vis_c;
    take_c   = de_c && pixel_valid;
    miss_c   = de_c && !pixel_valid;
  end

  assign pixel_ready = de_c && !rst;

  // Free-running raster counters plus next values of every registered output.
  always_comb begin
    h_cnt_d = h_cnt_q + HCW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HCW'(HW - 1)) begin
      h_cnt_d = '0;
      if (v_cnt_q == VCW'(VW - 1)) v_cnt_d = '0;
      else                         v_cnt_d = v_cnt_q + VCW'(1);
    end
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    dvi_h_d       = hsync_c  ? SYNC_POLARITY : ~SYNC_POLARITY;
    dvi_v_d       = v_sync_c ? SYNC_POLARITY : ~SYNC_POLARITY;
    dvi_de_d      = de_c;
    rise_d        = '0;
    fall_d        = '0;
    if (take_c) begin
      rise_d = {1'b0, pixel_data[14:10], pixel_data[9:8], 4'b0000};
      fall_d = {pixel_data[7:5], pixel_data[4:0], 4'b0000};
    end
    underflow_d = underflow_q || miss_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
      dvi_h_q       <= ~SYNC_POLARITY;
      dvi_v_q       <= ~SYNC_POLARITY;
      dvi_de_q      <= 1'b0;
      rise_q        <= '0;
      fall_q        <= '0;
      underflow_q   <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
      dvi_h_q       <= dvi_h_d;
      dvi_v_q       <= dvi_v_d;
      dvi_de_q      <= dvi_de_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      underflow_q   <= underflow_d;
    end
  end

  assign frame_start   = frame_start_q;
  assign dvi_h         = dvi_h_q;
  assign dvi_v         = dvi_v_q;
  assign dvi_de        = dvi_de_q;
  assign dvi_data_rise = rise_q;
  assign dvi_data_fall = fall_q;
  assign underflow     = underflow_q;

`ifdef DVI_UNDERFLOW_COUNT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  // Saturating count of black pixels substituted for missing source data.
  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (miss_c && (uf_cnt_q != 16'hFFFF)) uf_cnt_d = uf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) uf_cnt_q <= '0;
    else     uf_cnt_q <= uf_cnt_d;
  end

  assign underflow_count = uf_cnt_q;
`else
  assign underflow_count = 16'h0000;
`endif

endmodule
